ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Memory-side responder for the cpu_ram_if ram modport. Accepts word
//  read/write requests (ramREN/ramWEN/ramaddr/ramstore) from the
//  CPU-side arbiter and answers with ramstate/ramload after a
//  configurable latency. It backs a word-addressed SRAM array and is used
//  as the bring-up and simulation RAM behind the memory controller.
// PARAMETERS
//  LAT     2   cycles from request-seen to ACCESS; legal range is >= 1
//  ADDR_W  10  word-index width; array holds 2**ADDR_W 32-bit words
// PORTS
//  CLK       in   1   system clock, rising edge
//  nRST      in   1   asynchronous, active-low reset
//  ramaddr   in   32  byte address; bits [1:0] must be 0
//  ramstore  in   32  write data
//  ramREN    in   1   read request, level, held until ACCESS
//  ramWEN    in   1   write request, level, held until ACCESS
//  ramstate  out  2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  ramload   out  32  read data, valid in the ACCESS cycle of a read
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-low.
//  - Reset: ramstate=FREE, ramload=0, cnt=0, latched request cleared.
//    Array contents are not reset and survive nRST.
//  - All outputs are registered. Cycle 0 is the first cycle a request is
//    present on the inputs.
//  - Request key is {ramREN, ramWEN, ramaddr}. It is latched at the
//    cycle-0 edge; cnt starts at 1 and increments on each edge while
//    the key is unchanged.
//  - Index is ramaddr[ADDR_W+1:2]. Bad request: ramREN&ramWEN, or
//    ramaddr[1:0]!=0, or ramaddr[31:ADDR_W+2]!=0.
//  - FSM, next state at each edge:
//    FREE:   no request -> FREE; bad -> ERROR; else BUSY (LAT=1: ACCESS).
//    BUSY:   request dropped -> FREE, no side effect;
//            key changed -> restart with cnt=1 (ERROR if the new key is
//            bad); cnt reaches LAT -> ACCESS; otherwise BUSY.
//    ACCESS: one cycle only. Request still present -> treat it as a new
//            request (BUSY, cnt=1); else FREE.
//    ERROR:  held while the bad request persists; then FREE, or BUSY if
//            the new key is good.
//  - On the edge entering ACCESS:
//    read:  ramload <= mem[idx].
//    write: mem[idx] <= ramstore (value at that edge); ramload keeps
//           its old value.
//    ACCESS is visible in cycle LAT.
//  - ERROR, FREE and aborted BUSY never modify mem or ramload.
//  - Reset mid-BUSY: the request is discarded and no write occurs.
//  - Counter width is $clog2(LAT+1); it saturates and never wraps.
// TESTING
//  1 LAT=2: write 0x10 <- 0xDEADBEEF. Required: BUSY in cycle 1, ACCESS
//    in cycle 2. Then read 0x10: ramload=0xDEADBEEF in its ACCESS cycle.
//  2 REN held 4 cycles at LAT=2, addr 0x10. Required: ramstate sequence
//    FREE,BUSY,ACCESS,BUSY,ACCESS; ramload stable at the stored value.
//  3 REN 0x10 for one cycle, then 0x14 (LAT=3). Required: counter
//    restarts; ACCESS 3 cycles after the 0x14 request, with mem[5] data.
//  4 REN&WEN together, then addr 0x11, then addr 0x4000 (ADDR_W=10).
//    Required: ERROR each time; mem and ramload unchanged.
//  5 WEN 0x20 <- 0x1234, nRST pulsed low in cycle 1. Required: FREE and
//    ramload=0 immediately; a later read of 0x20 returns the old value.
//  6 LAT=1: WEN 0x8 <- 0xA5A5A5A5. Required: ACCESS in cycle 1, no BUSY;
//    a read back returns 0xA5A5A5A5.

Source files
------------

// File: rtl/ram_responder.sv
// Word-addressed SRAM responder for the cpu_ram_if ram modport.
// Answers each held read/write request with ACCESS after LAT cycles, or ERROR for malformed requests.
module ram_responder #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [1:0]  ramstate,
  output logic [31:0] ramload
);

  // state  | meaning
  // FREE   | idle, no request outstanding
  // BUSY   | request latched, counting toward LAT
  // ACCESS | one-cycle completion; array read/written on entry
  // ERROR  | malformed request present
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [33:0]       key, key_q;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [2**ADDR_W];
  logic              req, bad, same;
  logic              mem_we, load_en;
  state_t            start_state;
  logic [CW-1:0]     start_cnt;

  assign key     = {ramREN, ramWEN, ramaddr};
  assign req     = ramREN | ramWEN;
  assign bad     = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                   (ramaddr[31:ADDR_W+2] != '0);
  assign same    = (key == key_q);
  assign idx     = ramaddr[ADDR_W+1:2];
  assign cnt_inc = (cnt == LAT_C) ? cnt : cnt + ONE_C;

  // A fresh request (from any state) either faults or begins a count of one.
  assign start_state = bad ? ERROR : ((LAT == 1) ? ACCESS : BUSY);
  assign start_cnt   = bad ? '0 : ONE_C;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FREE;
      cnt   <= '0;
      key_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      key_q <= key;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      FREE, ACCESS, ERROR: begin
        if (req) begin
          state_n = start_state;
          cnt_n   = start_cnt;
        end else begin
          state_n = FREE;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (!req) begin
          state_n = FREE;
          cnt_n   = '0;
        end else if (!same) begin
          state_n = start_state;
          cnt_n   = start_cnt;
        end else begin
          state_n = (cnt_inc == LAT_C) ? ACCESS : BUSY;
          cnt_n   = cnt_inc;
        end
      end
      default: begin
        state_n = FREE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    mem_we  = 1'b0;
    load_en = 1'b0;
    if (state_n == ACCESS) begin
      mem_we  = ramWEN;
      load_en = ramREN;
    end
  end

  // Array has no reset so contents survive nRST.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= ramstore;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ramload <= '0;
    end else if (load_en) begin
      ramload <= mem[idx];
    end
  end

  assign ramstate = state;

endmodule

// File: tb/tb_ram_responder.sv
// Directed scoreboard bench for ram_responder at LAT=2, LAT=3 and LAT=1.
// Stimulus pushes expected ACCESS/ERROR events; a negedge monitor pops and compares them.
module tb_ram_responder;

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load  [3];
  logic [1:0]  st    [3];
  logic [1:0]  prev  [3];

  int vectors;
  int miscompares;

  typedef struct {
    int          k;
    logic [1:0]  s;
    logic [31:0] ld;
    string       nm;
  } exp_t;

  exp_t expq[$];

  ram_responder #(.LAT(2), .ADDR_W(10)) u_lat2 (
    .CLK(clk), .nRST(rst_n), .ramaddr(addr[0]), .ramstore(store[0]),
    .ramREN(ren[0]), .ramWEN(wen[0]), .ramstate(st[0]), .ramload(load[0]));

  ram_responder #(.LAT(3), .ADDR_W(10)) u_lat3 (
    .CLK(clk), .nRST(rst_n), .ramaddr(addr[1]), .ramstore(store[1]),
    .ramREN(ren[1]), .ramWEN(wen[1]), .ramstate(st[1]), .ramload(load[1]));

  ram_responder #(.LAT(1), .ADDR_W(10)) u_lat1 (
    .CLK(clk), .nRST(rst_n), .ramaddr(addr[2]), .ramstore(store[2]),
    .ramREN(ren[2]), .ramWEN(wen[2]), .ramstate(st[2]), .ramload(load[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: an ACCESS cycle, or the first cycle of ERROR, is one response event.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && (st[k] == S_ACC || (st[k] == S_ERR && prev[k] != S_ERR))) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: inst %0d state %0d load %h, none expected",
                   k, st[k], load[k]);
        end else begin
          e = expq.pop_front();
          if (e.k != k || e.s != st[k] || e.ld != load[k]) begin
            miscompares++;
            $display("FAIL %s: got inst %0d state %0d load %h, expected inst %0d state %0d load %h",
                     e.nm, k, st[k], load[k], e.k, e.s, e.ld);
          end
        end
      end
      prev[k] = st[k];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    ren[k]   = r;
    wen[k]   = w;
    addr[k]  = a;
    store[k] = d;
  endtask

  task automatic push(input int k, input logic [1:0] s, input logic [31:0] ld,
                      input string nm);
    exp_t e;
    e.k  = k;
    e.s  = s;
    e.ld = ld;
    e.nm = nm;
    expq.push_back(e);
  endtask

  task automatic chk(input int k, input logic [1:0] s, input string nm);
    vectors++;
    if (st[k] !== s) begin
      miscompares++;
      $display("FAIL %s: inst %0d state %0d, expected %0d", nm, k, st[k], s);
    end
  endtask

  task automatic chk_load(input int k, input logic [31:0] ld, input string nm);
    vectors++;
    if (load[k] !== ld) begin
      miscompares++;
      $display("FAIL %s: inst %0d load %h, expected %h", nm, k, load[k], ld);
    end
  endtask

  // Full request: FREE in cycle 0, BUSY through cycle lat-1, ACCESS in cycle lat, then FREE.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic [31:0] ld,
                        input string nm);
    drive(k, r, w, a, d);
    push(k, S_ACC, ld, nm);
    chk(k, S_FREE, {nm, "_c0"});
    for (int c = 1; c < lat; c++) begin
      step(1);
      chk(k, S_BUSY, {nm, "_busy"});
    end
    step(1);
    chk(k, S_ACC, {nm, "_access"});
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    chk(k, S_FREE, {nm, "_done"});
  endtask

  task automatic bad_req(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] ld, input string nm);
    drive(k, r, w, a, d);
    push(k, S_ERR, ld, nm);
    step(1);
    chk(k, S_ERR, {nm, "_err"});
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    chk(k, S_FREE, {nm, "_free"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
      prev[k] = S_FREE;
    end
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk(k, S_FREE, "reset_state");
      chk_load(k, 32'h0, "reset_load");
    end

    // LAT=2 write then read back
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, "t1_write");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, "t1_read");

    // REN held four cycles: FREE,BUSY,ACCESS,BUSY,ACCESS
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    push(0, S_ACC, 32'hDEADBEEF, "t2_acc1");
    push(0, S_ACC, 32'hDEADBEEF, "t2_acc2");
    chk(0, S_FREE, "t2_c0");
    step(1); chk(0, S_BUSY, "t2_c1");
    step(1); chk(0, S_ACC,  "t2_c2");
    step(1); chk(0, S_BUSY, "t2_c3");
    step(1); chk(0, S_ACC,  "t2_c4");
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1); chk(0, S_FREE, "t2_c5");
    chk_load(0, 32'hDEADBEEF, "t2_load_stable");

    // LAT=3: fill mem[5], then switch address mid-BUSY so the count restarts
    access(1, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 3, 32'h0, "t3_fill");
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1); chk(1, S_BUSY, "t3_c1");
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
    push(1, S_ACC, 32'h0BADF00D, "t3_restart_read");
    step(1); chk(1, S_BUSY, "t3_c2");
    step(1); chk(1, S_BUSY, "t3_c3");
    step(1); chk(1, S_ACC,  "t3_c4");
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1); chk(1, S_FREE, "t3_done");

    // Malformed requests; several alias mem[4] so a stray write would show on read-back
    bad_req(0, 1'b1, 1'b1, 32'h10,   32'hFFFFFFFF, 32'hDEADBEEF, "t4_ren_wen");
    bad_req(0, 1'b0, 1'b1, 32'h11,   32'h11111111, 32'hDEADBEEF, "t4_misalign");
    bad_req(0, 1'b0, 1'b1, 32'h4000, 32'h22222222, 32'hDEADBEEF, "t4_range");
    bad_req(0, 1'b0, 1'b1, 32'h4010, 32'h33333333, 32'hDEADBEEF, "t4_range_alias");
    bad_req(0, 1'b1, 1'b0, 32'h13,   32'h0,        32'hDEADBEEF, "t4_read_misalign");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, "t4_readback");

    // Reset during BUSY discards the pending write
    access(0, 1'b0, 1'b1, 32'h20, 32'h5555AAAA, 2, 32'hDEADBEEF, "t5_prefill");
    drive(0, 1'b0, 1'b1, 32'h20, 32'h00001234);
    step(1); chk(0, S_BUSY, "t5_c1");
    rst_n = 1'b0;
    #1;
    chk(0, S_FREE, "t5_rst_state");
    chk_load(0, 32'h0, "t5_rst_load");
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b1;
    step(1); chk(0, S_FREE, "t5_after_rst");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h5555AAAA, "t5_read_old");

    // LAT=1: ACCESS directly in cycle 1
    access(2, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1, 32'h0, "t6_write");
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, 1, 32'hA5A5A5A5, "t6_read");

    step(2);
    while (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: event never seen, expected inst %0d state %0d load %h",
               e.nm, e.k, e.s, e.ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
